// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: lets two requesters share one combinational ALU.
// At most one requester is granted per cycle. The granted requester's opcode and
// operands are steered into the ALU, and the ALU outputs are captured in a
// 1-entry response register that the consumer drains with rsp_rdy_arb_i.
// A requester can lock ownership across several ops. The lock is released when
// the owner issues an op with lock low, or when the owner drops its request.
// Optional feature: define ALU_ARB_RR_EN to break ties round-robin.
// Without it, ties use fixed priority and requester 0 wins.
module alu_share_arbiter #(
    parameter int                DATA_W  = 32,
    parameter int                OP_W    = 6,
    parameter logic [OP_W-1:0]   OP_IDLE = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req0_arb_i,
    input  logic                 lock0_arb_i,
    input  logic [OP_W-1:0]      op0_arb_i,
    input  logic [DATA_W-1:0]    opr_a0_arb_i,
    input  logic [DATA_W-1:0]    opr_b0_arb_i,
    output logic                 gnt0_arb_o,
    input  logic                 req1_arb_i,
    input  logic                 lock1_arb_i,
    input  logic [OP_W-1:0]      op1_arb_i,
    input  logic [DATA_W-1:0]    opr_a1_arb_i,
    input  logic [DATA_W-1:0]    opr_b1_arb_i,
    output logic                 gnt1_arb_o,
    output logic [OP_W-1:0]      op_alu_o,
    output logic [DATA_W-1:0]    opr_a_alu_o,
    output logic [DATA_W-1:0]    opr_b_alu_o,
    input  logic [DATA_W-1:0]    res_alu_i,
    input  logic                 z_alu_i,
    input  logic                 n_alu_i,
    output logic                 vld0_arb_o,
    output logic                 vld1_arb_o,
    output logic [DATA_W-1:0]    res_arb_o,
    output logic                 z_arb_o,
    output logic                 n_arb_o,
    input  logic                 rsp_rdy_arb_i
);

    logic              vld_q;
    logic              id_q;
    logic              last_q;
    logic              lock_q;
    logic              lock_id_q;
    logic [DATA_W-1:0] res_q;
    logic              z_q;
    logic              n_q;

    logic              free;
    logic              gnt0;
    logic              gnt1;
    logic              gnt_any;
    logic              owner_req;

    // The slot is free when it is empty, or when it is being drained this cycle.
    assign free      = !vld_q | rsp_rdy_arb_i;
    assign gnt_any   = gnt0 | gnt1;
    assign owner_req = lock_id_q ? req1_arb_i : req0_arb_i;

`ifndef ALU_ARB_RR_EN
    // last_q is only consulted for round-robin ties. This keeps it visibly consumed.
    logic unused_last;
    assign unused_last = last_q;
`endif

    // Grant decision: lock owner first, then single requester, then tie-break.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset && free) begin
            if (lock_q) begin
                if (lock_id_q) gnt1 = req1_arb_i;
                else           gnt0 = req0_arb_i;
            end else if (req0_arb_i && req1_arb_i) begin
`ifdef ALU_ARB_RR_EN
                if (last_q) gnt0 = 1'b1;
                else        gnt1 = 1'b1;
`else
                gnt0 = 1'b1;
`endif
            end else begin
                gnt0 = req0_arb_i;
                gnt1 = req1_arb_i;
            end
        end
    end

    // Steer the granted requester into the ALU. Drive idle values when nobody is granted.
    always_comb begin
        op_alu_o    = OP_IDLE;
        opr_a_alu_o = '0;
        opr_b_alu_o = '0;
        if (gnt0) begin
            op_alu_o    = op0_arb_i;
            opr_a_alu_o = opr_a0_arb_i;
            opr_b_alu_o = opr_b0_arb_i;
        end else if (gnt1) begin
            op_alu_o    = op1_arb_i;
            opr_a_alu_o = opr_a1_arb_i;
            opr_b_alu_o = opr_b1_arb_i;
        end
    end

    // Response register, ownership history and lock tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q     <= 1'b0;
            id_q      <= 1'b0;
            last_q    <= 1'b1;
            lock_q    <= 1'b0;
            lock_id_q <= 1'b0;
            res_q     <= '0;
            z_q       <= 1'b0;
            n_q       <= 1'b0;
        end else begin
            if (gnt_any) begin
                vld_q  <= 1'b1;
                id_q   <= gnt1;
                last_q <= gnt1;
                res_q  <= res_alu_i;
                z_q    <= z_alu_i;
                n_q    <= n_alu_i;
            end else if (rsp_rdy_arb_i) begin
                vld_q  <= 1'b0;
            end

            // A granted op sets the lock state from its own lock bit, which covers
            // both acquiring the lock and releasing it. If the owner stops requesting,
            // the lock is dropped so the other requester cannot starve.
            if (gnt_any) begin
                lock_q    <= gnt1 ? lock1_arb_i : lock0_arb_i;
                lock_id_q <= gnt1;
            end else if (lock_q && !owner_req) begin
                lock_q    <= 1'b0;
            end
        end
    end

    assign gnt0_arb_o = gnt0;
    assign gnt1_arb_o = gnt1;
    assign vld0_arb_o = vld_q & !id_q;
    assign vld1_arb_o = vld_q &  id_q;
    assign res_arb_o  = res_q;
    assign z_arb_o    = z_q;
    assign n_arb_o    = n_q;

endmodule
